countdown_ctrl: RTL and testbench

- Control FSM for the 3-digit BCD countdown stopwatch datapath. Default preset is 1:00.
- Conditions the raw start/pause and clear push-buttons: 2-FF synchroniser, debounce, then one-pulse.
- Generates the prescaled one-cycle decrement enable and the reload (clear) strobe.
- Watches the datapath's zero flag; drives the run/pause/done status and a blinking alarm.
- Sits between the board buttons/LEDs and the countdown datapath.

---
 rtl/countdown_ctrl.sv | 163 ++++++++++++++++
 tb/tb_countdown_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Control FSM for the 3-digit BCD countdown stopwatch: button conditioning,
// tick prescaler, run/pause/done sequencing, reload strobe and blinking alarm.
module countdown_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_i,
  input  logic       btn_clear_i,
  input  logic       cnt_stop_i,
  output logic       cnt_en_o,
  output logic       cnt_clr_n_o,
  output logic [1:0] state_o,
  output logic       alarm_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  logic          start_s1_q, start_s2_q;
  logic          clear_s1_q, clear_s2_q;
  logic          start_deb_q, start_deb_d;
  logic          clear_deb_q, clear_deb_d;
  logic [DW-1:0] start_cnt_q, start_cnt_d;
  logic [DW-1:0] clear_cnt_q, clear_cnt_d;
  logic          start_prev_q, clear_prev_q;
  logic          start_p, clear_p;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_inc;
  logic          tick;
  logic          clr_n_q;
  logic          alarm_q;

  // A new debounced level is accepted only after the synchronised level has
  // disagreed with it for DEB_CYCLES consecutive cycles.
  always_comb begin
    start_deb_d = start_deb_q;
    start_cnt_d = '0;
    if (start_s2_q != start_deb_q) begin
      if (start_cnt_q == DEB_MAX) start_deb_d = start_s2_q;
      else                        start_cnt_d = start_cnt_q + 1'b1;
    end
  end

  always_comb begin
    clear_deb_d = clear_deb_q;
    clear_cnt_d = '0;
    if (clear_s2_q != clear_deb_q) begin
      if (clear_cnt_q == DEB_MAX) clear_deb_d = clear_s2_q;
      else                        clear_cnt_d = clear_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      clear_s1_q   <= 1'b0;
      clear_s2_q   <= 1'b0;
      start_deb_q  <= 1'b0;
      clear_deb_q  <= 1'b0;
      start_cnt_q  <= '0;
      clear_cnt_q  <= '0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      start_s1_q   <= btn_start_i;
      start_s2_q   <= start_s1_q;
      clear_s1_q   <= btn_clear_i;
      clear_s2_q   <= clear_s1_q;
      start_deb_q  <= start_deb_d;
      clear_deb_q  <= clear_deb_d;
      start_cnt_q  <= start_cnt_d;
      clear_cnt_q  <= clear_cnt_d;
      start_prev_q <= start_deb_q;
      clear_prev_q <= clear_deb_q;
    end
  end

  assign start_p = start_deb_q & ~start_prev_q;
  assign clear_p = clear_deb_q & ~clear_prev_q;

  assign tick      = (presc_q == PRESC_MAX);
  assign presc_inc = tick ? '0 : presc_q + 1'b1;

  // Priority in every state: clear_p, then cnt_stop_i, then start_p.
  // The prescaler restarts from 0 on entry to RUN from IDLE and on entry to
  // DONE, and simply holds while paused so the partial second survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      clr_n_q <= 1'b1;
      alarm_q <= 1'b0;
    end else begin
      clr_n_q <= ~clear_p;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          alarm_q <= 1'b0;
          if (!clear_p && start_p) begin
            if (cnt_stop_i) begin
              state_q <= S_DONE;
              alarm_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          alarm_q <= 1'b0;
          presc_q <= presc_inc;
          if (clear_p) begin
            state_q <= S_IDLE;
          end else if (cnt_stop_i) begin
            state_q <= S_DONE;
            presc_q <= '0;
            alarm_q <= 1'b1;
          end else if (start_p) begin
            state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          alarm_q <= 1'b0;
          if (clear_p)      state_q <= S_IDLE;
          else if (start_p) state_q <= S_RUN;
        end
        S_DONE: begin
          presc_q <= presc_inc;
          if (clear_p) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
          end else if (tick) begin
            alarm_q <= ~alarm_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          presc_q <= '0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en_o    = tick && (state_q == S_RUN);
  assign cnt_clr_n_o = clr_n_q;
  assign state_o     = state_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a seconds-level model of the 1:00
// countdown datapath feeding cnt_stop_i.
module tb_countdown_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int PRESET     = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start_i;
  logic       btn_clear_i;
  logic       cnt_stop_i;
  logic       cnt_en_o;
  logic       cnt_clr_n_o;
  logic [1:0] state_o;
  logic       alarm_o;

  int n_checks  = 0;
  int n_errors  = 0;
  int model_cnt = PRESET;
  int en_pulses = 0;

  countdown_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_i (btn_start_i),
    .btn_clear_i (btn_clear_i),
    .cnt_stop_i  (cnt_stop_i),
    .cnt_en_o    (cnt_en_o),
    .cnt_clr_n_o (cnt_clr_n_o),
    .state_o     (state_o),
    .alarm_o     (alarm_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  always @(posedge clk or negedge cnt_clr_n_o) begin
    if (!cnt_clr_n_o)                      model_cnt <= PRESET;
    else if (cnt_en_o && model_cnt != 0)   model_cnt <= model_cnt - 1;
  end
  assign cnt_stop_i = (model_cnt == 0);

  always @(negedge clk) if (cnt_en_o) en_pulses <= en_pulses + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start(input int hold);
    btn_start_i = 1'b1;
    step(hold);
    btn_start_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n       = 1'b0;
    btn_start_i = 1'b0;
    btn_clear_i = 1'b0;
    step(3);
    check("rst_state", state_o, 0);
    check("rst_clr_n", cnt_clr_n_o, 1);
    check("rst_alarm", alarm_o, 0);
    check("rst_en", cnt_en_o, 0);
    rst_n = 1'b1;
    step(2);

    // Short start bounce and single-cycle clear glitch: nothing may happen.
    btn_start_i = 1'b1;
    step(2);
    btn_start_i = 1'b0;
    btn_clear_i = 1'b1;
    step(1);
    btn_clear_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_state", state_o, 0);
      check("glitch_clr_n", cnt_clr_n_o, 1);
    end

    // Clean start, ticks, pause at prescaler 2, resume.
    btn_start_i = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      logic [1:0] exp_state;
      logic       exp_en;
      step(1);
      if (k < 6)       exp_state = 2'd0;
      else if (k < 24) exp_state = 2'd1;
      else if (k < 34) exp_state = 2'd2;
      else             exp_state = 2'd1;
      if (k < 6)       exp_en = 1'b0;
      else if (k < 24) exp_en = ((k - 6) % 4 == 3);
      else if (k < 34) exp_en = 1'b0;
      else             exp_en = ((k - 34) % 4 == 1);
      check($sformatf("run_state_k%0d", k), state_o, exp_state);
      check($sformatf("run_en_k%0d", k), cnt_en_o, exp_en);
      if (k == 10 || k == 22 || k == 32) btn_start_i = 1'b0;
      if (k == 18 || k == 28)            btn_start_i = 1'b1;
    end
    check("model_mid", model_cnt, PRESET - 4);

    // Count down to zero.
    guard = 0;
    while (model_cnt != 0 && guard < 400) begin
      step(1);
      guard++;
    end
    check("rundown_timeout", guard < 400, 1);
    check("run_last_state", state_o, 1);
    step(1);
    check("done_state", state_o, 3);
    check("done_pulses", en_pulses, PRESET);
    check("done_alarm0", alarm_o, 1);

    // DONE: alarm blink, ignored start, then clear.
    for (int j = 1; j <= 26; j++) begin
      step(1);
      if (j < 22) begin
        check($sformatf("done_state_j%0d", j), state_o, 3);
        check($sformatf("done_alarm_j%0d", j), alarm_o, ((j / 4) % 2 == 0));
        check($sformatf("done_en_j%0d", j), cnt_en_o, 0);
      end else if (j == 22) begin
        check("clr_state", state_o, 0);
        check("clr_strobe", cnt_clr_n_o, 0);
        check("clr_alarm", alarm_o, 0);
        check("clr_model", model_cnt, PRESET);
      end else begin
        check($sformatf("idle_state_j%0d", j), state_o, 0);
        check($sformatf("idle_clr_n_j%0d", j), cnt_clr_n_o, 1);
      end
      if (j == 1)  btn_start_i = 1'b1;
      if (j == 5)  btn_start_i = 1'b0;
      if (j == 16) btn_clear_i = 1'b1;
      if (j == 20) btn_clear_i = 1'b0;
    end

    // RUN, PAUSE, then start and clear together.
    press_start(4);
    step(2);
    check("restart_state", state_o, 1);
    step(4);
    press_start(4);
    step(2);
    check("pause2_state", state_o, 2);
    step(4);
    btn_start_i = 1'b1;
    btn_clear_i = 1'b1;
    step(4);
    btn_start_i = 1'b0;
    btn_clear_i = 1'b0;
    step(2);
    check("both_state", state_o, 0);
    check("both_strobe", cnt_clr_n_o, 0);
    step(1);
    check("both_clr_n_after", cnt_clr_n_o, 1);
    check("both_state_after", state_o, 0);
    step(1);
    check("both_state_late", state_o, 0);
    step(2);

    // Reset asserted while a start press is mid-debounce in RUN.
    press_start(4);
    step(2);
    check("pre_rst_state", state_o, 1);
    step(4);
    btn_start_i = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state_o, 0);
    check("arst_en", cnt_en_o, 0);
    check("arst_clr_n", cnt_clr_n_o, 1);
    check("arst_alarm", alarm_o, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("post_rst_state5", state_o, 0);
    step(1);
    check("post_rst_state6", state_o, 1);
    btn_start_i = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
